// File: rtl/spi_deserializer.sv
// SPI receive path: synchronizes sclk/mosi, assembles MSB-first words and hands
// them to the receive FIFO through a single-word holding buffer.
module spi_deserializer #(
    parameter int DATAWIDTH      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 full,
    input  logic                 clear_err,
    output logic [DATAWIDTH-1:0] writeData,
    output logic                 writeEn,
    output logic                 overflow,
    output logic                 frame_error,
    output logic                 busy,
    output logic [15:0]          rx_count
);

    localparam int CW = $clog2(DATAWIDTH);
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync;
    logic                   sclk_s, mosi_s, sclk_d, rise;
    logic [DATAWIDTH-2:0]   shift_reg;
    logic [CW-1:0]          bit_cnt;
    logic [IW-1:0]          idle_cnt;
    logic [DATAWIDTH-1:0]   hold_reg;
    logic                   hold_valid;
    logic                   complete, timeout;
    logic [DATAWIDTH-1:0]   word;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign word   = {shift_reg, mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_d = SHIFT;
            end
            SHIFT: begin
                if (rise) begin
                    if (bit_cnt == CW'(DATAWIDTH - 1)) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
        end else if (rise) begin
            shift_reg <= word[DATAWIDTH-2:0];
            bit_cnt   <= complete ? '0 : bit_cnt + 1'b1;
            idle_cnt  <= '0;
        end else if (timeout) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
        end else if (state == SHIFT) begin
            idle_cnt  <= idle_cnt + 1'b1;
        end else begin
            idle_cnt  <= '0;
        end
    end

    // A word completing in the same cycle the held word drains takes its place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            rx_count   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (complete && (!hold_valid || writeEn)) begin
                hold_reg   <= word;
                hold_valid <= 1'b1;
                rx_count   <= rx_count + 16'd1;
            end else if (writeEn) begin
                hold_valid <= 1'b0;
            end
            if (complete && hold_valid && !writeEn) overflow <= 1'b1;
            else if (clear_err)                     overflow <= 1'b0;
        end
    end

    assign writeEn     = hold_valid & ~full;
    assign writeData   = hold_reg;
    assign frame_error = timeout;
    assign busy        = (state == SHIFT);

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed and randomized bench for spi_deserializer; words observed on the
// FIFO write port are compared against a queue-based reference model.
module tb_spi_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        full = 1'b0;
    logic        clear_err = 1'b0;
    logic [31:0] writeData;
    logic        writeEn;
    logic        overflow;
    logic        frame_error;
    logic        busy;
    logic [15:0] rx_count;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    spi_deserializer #(.DATAWIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .full(full),
        .clear_err(clear_err), .writeData(writeData), .writeEn(writeEn),
        .overflow(overflow), .frame_error(frame_error), .busy(busy),
        .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (writeEn) got_q.push_back(writeData);
            if (frame_error) fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // action: 0 none, 1 pulse clear_err in the completion cycle, 2 drop full there
    task automatic send_bit(input logic b, input int action);
        mosi = b;
        sclk = 1'b0;
        cycles($urandom_range(3, 6));
        sclk = 1'b1;
        if (action != 0) begin
            cycles(2);
            if (action == 1) clear_err = 1'b1;
            else             full = 1'b0;
            cycles(1);
            clear_err = 1'b0;
            cycles(1);
        end else begin
            cycles($urandom_range(3, 6));
        end
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits, input int action);
        for (int i = 31; i > 31 - nbits; i--)
            send_bit(w[i], (i == 0) ? action : 0);
        cycles(4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        full = 1'b0;
        cycles(2);
        rst = 1'b0;
        got_q.delete();
        fe_cnt = 0;
        cycles(2);
    endtask

    initial begin
        logic [31:0] w;
        cycles(3);
        check("rst_data", writeData, 32'h0);
        check("rst_wen", {31'h0, writeEn}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_fe", {31'h0, frame_error}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_cnt", {16'h0, rx_count}, 32'h0);
        rst = 1'b0;
        cycles(2);

        send_word(32'hA5A51234, 32, 0);
        cycles(4);
        check("single_n", got_q.size(), 1);
        if (got_q.size() > 0) check("single_data", got_q[0], 32'hA5A51234);
        check("single_cnt", {16'h0, rx_count}, 1);
        check("single_busy", {31'h0, busy}, 0);

        do_reset();
        full = 1'b1;
        send_word(32'h11111111, 32, 0);
        send_word(32'h22222222, 32, 1);
        check("ovf_set_wins", {31'h0, overflow}, 1);
        check("ovf_nowrite", got_q.size(), 0);
        full = 1'b0;
        cycles(4);
        check("ovf_n", got_q.size(), 1);
        if (got_q.size() > 0) check("ovf_data", got_q[0], 32'h11111111);
        check("ovf_cnt", {16'h0, rx_count}, 1);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        check("ovf_clear", {31'h0, overflow}, 0);

        do_reset();
        full = 1'b1;
        send_word(32'h11111111, 32, 0);
        send_word(32'h22222222, 32, 2);
        cycles(4);
        check("edge_n", got_q.size(), 2);
        if (got_q.size() > 1) begin
            check("edge_d0", got_q[0], 32'h11111111);
            check("edge_d1", got_q[1], 32'h22222222);
        end
        check("edge_ovf", {31'h0, overflow}, 0);
        check("edge_cnt", {16'h0, rx_count}, 2);

        do_reset();
        send_word(32'hFFC00000, 10, 0);
        cycles(40);
        check("to_early_fe", fe_cnt, 0);
        check("to_busy", {31'h0, busy}, 1);
        cycles(60);
        check("to_fe_pulse", fe_cnt, 1);
        check("to_idle", {31'h0, busy}, 0);
        check("to_nowrite", got_q.size(), 0);
        send_word(32'hDEADBEEF, 32, 0);
        cycles(4);
        check("to_next_n", got_q.size(), 1);
        if (got_q.size() > 0) check("to_next_data", got_q[0], 32'hDEADBEEF);

        do_reset();
        full = 1'b1;
        send_word(32'hCAFEF00D, 32, 0);
        send_word(32'h12345678, 16, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_data", writeData, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_cnt", {16'h0, rx_count}, 0);
        cycles(2);
        rst = 1'b0;
        full = 1'b0;
        got_q.delete();
        cycles(6);
        check("mid_rst_nohold", got_q.size(), 0);
        send_word(32'h0000FFFF, 32, 0);
        cycles(4);
        check("mid_rst_n", got_q.size(), 1);
        if (got_q.size() > 0) check("mid_rst_word", got_q[0], 32'h0000FFFF);
        check("mid_rst_cnt1", {16'h0, rx_count}, 1);

        // Random words with no back-pressure: every word must appear, in order.
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            w = $urandom();
            exp_q.push_back(w);
            send_word(w, 32, 0);
            cycles($urandom_range(0, 20));
        end
        cycles(4);
        check("rand_n", got_q.size(), exp_q.size());
        for (int k = 0; k < 8; k++)
            if (k < got_q.size()) check($sformatf("rand_w%0d", k), got_q[k], exp_q[k]);
        check("rand_cnt", {16'h0, rx_count}, exp_q.size());
        check("rand_ovf", {31'h0, overflow}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
